// File: rtl/seg_msg_scan.sv
// Multiplexed 7-segment message driver: latches one of four 4-char messages on start,
// scans the digits, optionally blinks, and blanks with a done pulse after the hold time.
//   state | meaning
//   IDLE  | display blank, counters held at 0
//   ON    | message lit (even phase)
//   OFF   | dark if blinking, else still lit (odd phase)
module seg_msg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 125,
  parameter int HOLD_BLINKS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            msg_sel,
  input  logic                  blink_en,
  input  logic                  en,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] com,
  output logic                  busy,
  output logic                  done
);

  localparam int NUM_PHASES = 2 * HOLD_BLINKS;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(NUM_PHASES - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] digit;
  logic [FW-1:0] frame_cnt;
  logic [PW-1:0] phase_cnt;
  logic [1:0]    msg_q;
  logic          blink_q;
  logic          clear, done_d;
  logic          scan_last, digit_last, frame_last, phase_end;
  logic          show;
  logic [3:0]    dig_ext;
  logic [6:0]    char_seg;
  logic [NUM_DIGITS-1:0] com_onehot;

  assign scan_last  = (scan_cnt == SCAN_LAST);
  assign digit_last = (digit == DIGIT_LAST);
  assign frame_last = (frame_cnt == FRAME_LAST);
  assign phase_end  = scan_last && digit_last && frame_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A start in any state restarts the display and suppresses the done pulse.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    done_d  = 1'b0;
    if (start) begin
      state_d = ON;
      clear   = 1'b1;
    end else begin
      case (state_q)
        ON:  if (phase_end) state_d = OFF;
        OFF: if (phase_end) begin
               if (phase_cnt == PHASE_LAST) begin
                 state_d = IDLE;
                 done_d  = 1'b1;
               end else begin
                 state_d = ON;
               end
             end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit     <= '0;
      frame_cnt <= '0;
      phase_cnt <= '0;
    end else if (clear || state_q == IDLE) begin
      scan_cnt  <= '0;
      digit     <= '0;
      frame_cnt <= '0;
      phase_cnt <= '0;
    end else if (!scan_last) begin
      scan_cnt <= scan_cnt + SW'(1);
    end else begin
      scan_cnt <= '0;
      if (!digit_last) begin
        digit <= digit + DW'(1);
      end else begin
        digit <= '0;
        if (!frame_last) begin
          frame_cnt <= frame_cnt + FW'(1);
        end else begin
          frame_cnt <= '0;
          phase_cnt <= (phase_cnt == PHASE_LAST) ? '0 : phase_cnt + PW'(1);
        end
      end
    end
  end

  // Digits beyond the fourth scan their common line but carry no character.
  always_comb begin
    dig_ext  = 4'(digit);
    char_seg = 7'h00;
    if (dig_ext < 4'd4) begin
      case ({msg_q, dig_ext[1:0]})
        4'b00_00: char_seg = 7'h47;
        4'b00_01: char_seg = 7'h77;
        4'b00_10: char_seg = 7'h30;
        4'b00_11: char_seg = 7'h0E;
        4'b01_00: char_seg = 7'h7E;
        4'b01_01: char_seg = 7'h67;
        4'b01_10: char_seg = 7'h4F;
        4'b01_11: char_seg = 7'h15;
        4'b10_00, 4'b10_01, 4'b10_10, 4'b10_11: char_seg = 7'h01;
        default: char_seg = 7'h7F;
      endcase
    end
  end

  assign com_onehot = NUM_DIGITS'(1) << digit;
  assign show = en && ((state_q == ON) || (state_q == OFF && !blink_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg     <= '0;
      com     <= '0;
      done    <= 1'b0;
      msg_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      seg  <= show ? char_seg : '0;
      com  <= show ? com_onehot : '0;
      done <= done_d;
      if (start) begin
        msg_q   <= msg_sel;
        blink_q <= blink_en;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule
